// File: rtl/cluster_clock_switch_ctrl.sv
// rtl/cluster_clock_switch_ctrl.sv - request-driven select controller for a downstream glitchless 2:1 clock mux
module cluster_clock_switch_ctrl #(
  parameter int   SYNC_STAGES    = 2,
  parameter int   SETTLE_CYCLES  = 8,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic RESET_SEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  output logic req_ready_o,
  input  logic req_sel_i,
  input  logic clk0_stable_i,
  input  logic clk1_stable_i,
  output logic clk_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic cur_sel_o
);

  localparam int MAX_COUNT = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STABLE,
    SWITCH,
    DONE
  } state_t;

  state_t          state, state_n;
  logic            target, target_n;
  logic            clk_sel, clk_sel_n;
  logic            cur_sel, cur_sel_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            fail, fail_n;
  logic            done, done_n;
  logic            err, err_n;

  logic [SYNC_STAGES-1:0] sync0;
  logic [SYNC_STAGES-1:0] sync1;
  logic                   stable0;
  logic                   stable1;
  logic                   target_stable;

  // Stable flags come from other clock domains; only the last stage is ever looked at.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], clk0_stable_i};
      sync1 <= {sync1[SYNC_STAGES-2:0], clk1_stable_i};
    end
  end

  assign stable0       = sync0[SYNC_STAGES-1];
  assign stable1       = sync1[SYNC_STAGES-1];
  assign target_stable = target ? stable1 : stable0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      target  <= RESET_SEL;
      clk_sel <= RESET_SEL;
      cur_sel <= RESET_SEL;
      cnt     <= '0;
      fail    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      target  <= target_n;
      clk_sel <= clk_sel_n;
      cur_sel <= cur_sel_n;
      cnt     <= cnt_n;
      fail    <= fail_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target;
    clk_sel_n = clk_sel;
    cur_sel_n = cur_sel;
    cnt_n     = cnt;
    fail_n    = fail;
    done_n    = 1'b0;
    err_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          target_n = req_sel_i;
          cnt_n    = '0;
          fail_n   = 1'b0;
          if (req_sel_i == cur_sel) begin
            state_n = DONE;
          end else begin
            state_n = WAIT_STABLE;
          end
        end
      end

      // A stable flag that drops again while waiting does not restart the timeout.
      WAIT_STABLE: begin
        if (target_stable) begin
          clk_sel_n = target;
          cnt_n     = '0;
          state_n   = SWITCH;
        end else if (cnt == TIMEOUT_LAST) begin
          fail_n  = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // The mux is mid-handoff here, so stable changes are deliberately ignored.
      SWITCH: begin
        if (cnt == SETTLE_LAST) begin
          cur_sel_n = target;
          fail_n    = 1'b0;
          state_n   = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DONE: begin
        done_n  = 1'b1;
        err_n   = fail;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign clk_sel_o   = clk_sel;
  assign cur_sel_o   = cur_sel;
  assign done_o      = done;
  assign err_o       = err;

endmodule

// File: tb/tb_cluster_clock_switch_ctrl.sv
// tb/tb_cluster_clock_switch_ctrl.sv - scoreboard bench for cluster_clock_switch_ctrl
module tb_cluster_clock_switch_ctrl;

  localparam int SYNC    = 2;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 64;
  localparam int LAT_SW  = SETTLE + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic clk0_stable = 1'b0;
  logic clk1_stable = 1'b1;
  logic req_ready_o, clk_sel_o, busy_o, done_o, err_o, cur_sel_o;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_expected = 0;

  typedef struct packed {
    logic err;
    logic sel;
    int   due;
  } exp_t;

  exp_t exp_q[$];

  cluster_clock_switch_ctrl #(
    .SYNC_STAGES(SYNC),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .RESET_SEL(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_sel_i(req_sel),
    .clk0_stable_i(clk0_stable),
    .clk1_stable_i(clk1_stable),
    .clk_sel_o(clk_sel_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .cur_sel_o(cur_sel_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("done_err", int'(err_o), int'(e.err));
        check("done_cur_sel", int'(cur_sel_o), int'(e.sel));
        check("done_clk_sel", int'(clk_sel_o), int'(e.sel));
      end
    end else if (!rst && err_o) begin
      check("err_without_done", int'(err_o), 0);
    end
  end

  task automatic request(input logic sel, input bit expect_done, input logic exp_err,
                         input logic exp_sel, input int lat, output int hs);
    int guard;
    req_sel   = sel;
    req_valid = 1'b1;
    guard     = 0;
    while (!req_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    hs = cyc;
    if (expect_done) begin
      exp_q.push_back('{exp_err, exp_sel, hs + lat});
      n_expected++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy_o) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_cycle(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 300) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int hs, hs_a, hs_b;

    repeat (3) @(negedge clk);
    check("rst_clk_sel", int'(clk_sel_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_clk_sel", int'(clk_sel_o), 0);
    check("idle_cur_sel", int'(cur_sel_o), 0);
    check("idle_ready", int'(req_ready_o), 1);
    check("idle_busy", int'(busy_o), 0);
    check("idle_done", int'(done_o), 0);
    check("idle_err", int'(err_o), 0);
    repeat (3) @(negedge clk);

    // Switch to an already-stable clk1.
    request(1'b1, 1'b1, 1'b0, 1'b1, LAT_SW, hs);
    check("sw1_sel_hs", int'(clk_sel_o), 0);
    check("sw1_ready_low", int'(req_ready_o), 0);
    check("sw1_busy", int'(busy_o), 1);
    @(negedge clk);
    check("sw1_sel_c1", int'(clk_sel_o), 1);
    check("sw1_cur_c1", int'(cur_sel_o), 0);
    wait_drain();

    // Same-select request.
    request(1'b1, 1'b1, 1'b0, 1'b1, 1, hs);
    check("same_sel_hs", int'(clk_sel_o), 1);
    wait_drain();

    // clk0 becomes stable only 50 cycles after the handshake.
    request(1'b0, 1'b1, 1'b0, 1'b0, 50 + SYNC + 1 + SETTLE + 1, hs);
    wait_cycle(hs + 50);
    clk0_stable = 1'b1;
    wait_cycle(hs + 50 + SYNC);
    check("late_sel_before", int'(clk_sel_o), 1);
    @(negedge clk);
    check("late_sel_after", int'(clk_sel_o), 0);
    wait_drain();

    // Timeout: clk1 never becomes stable.
    clk1_stable = 1'b0;
    repeat (5) @(negedge clk);
    request(1'b1, 1'b1, 1'b1, 1'b0, TIMEOUT + 1, hs);
    wait_drain();
    check("to_ready_after", int'(req_ready_o), 1);
    check("to_clk_sel", int'(clk_sel_o), 0);

    // Back-pressure: second request is held valid while the first is busy.
    clk1_stable = 1'b1;
    repeat (5) @(negedge clk);
    request(1'b1, 1'b1, 1'b0, 1'b1, LAT_SW, hs_a);
    request(1'b0, 1'b1, 1'b0, 1'b0, LAT_SW, hs_b);
    check("bp_accept_cycle", hs_b, hs_a + LAT_SW + 1);
    wait_drain();

    // Reset three cycles into SWITCH: select reverts at once, no done.
    request(1'b1, 1'b0, 1'b0, 1'b1, 0, hs);
    wait_cycle(hs + 3);
    check("mid_sel_before", int'(clk_sel_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_clk_sel", int'(clk_sel_o), 0);
    check("mid_rst_cur_sel", int'(cur_sel_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_clk_sel", int'(clk_sel_o), 0);

    check("queue_empty", exp_q.size(), 0);
    check("done_count", n_done, n_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_clock_switch_ctrl.md
Name: cluster_clock_switch_ctrl

Overview:
Single-clock controller that generates the select for a downstream 2-to-1 glitchless clock mux from a software/PMU switch request. It accepts a valid/ready request and waits until the target clock source reports stable. It then drives the mux select and holds off completion until the mux's internal handoff has settled. The block runs on an always-on reference clock and reports completion or timeout to the requester.

Parameters:
SYNC_STAGES, 2, flops in each stable-input synchronizer (min 2)
SETTLE_CYCLES, 8, ref-clock cycles to wait after changing select before reporting done (min 1)
TIMEOUT_CYCLES, 1024, max cycles to wait for target stable before aborting (min 1)
RESET_SEL, 1'b0, clk_sel_o value after reset

Ports:
clk_i  in  1  always-on reference clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  switch request valid
req_ready_o  out  1  controller can accept request (high only in IDLE)
req_sel_i  in  1  requested source: 0=clk0, 1=clk1
clk0_stable_i  in  1  clk0 source stable (asynchronous, synchronized internally)
clk1_stable_i  in  1  clk1 source stable (asynchronous, synchronized internally)
clk_sel_o  out  1  select to glitchless mux, registered
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse: request finished
err_o  out  1  qualifies done_o: 1=timeout, select unchanged
cur_sel_o  out  1  select currently committed (equals clk_sel_o except during SWITCH)

Behaviour:
- Reset (async assert, sync release): state=IDLE, clk_sel_o=cur_sel_o=RESET_SEL, req_ready_o=1, busy_o=0, done_o=0, err_o=0, counters=0, synchronizers=0.
- Stable inputs pass through SYNC_STAGES-flop synchronizers. All decisions use the synchronized values.
- FSM states: IDLE, WAIT_STABLE, SWITCH, DONE.
- IDLE:
  - Handshake occurs when req_valid_i & req_ready_o; req_sel_i is latched as target.
  - If target == cur_sel_o → DONE (no select change, err=0).
  - Else → WAIT_STABLE, timeout counter cleared.
- WAIT_STABLE:
  - Synchronized stable of target high → drive clk_sel_o=target in the same transition, settle counter cleared → SWITCH.
  - Else, if timeout counter reaches TIMEOUT_CYCLES-1 → DONE with err=1; clk_sel_o unchanged.
  - Else increment the counter.
  - Stable going low again while waiting does not reset the counter.
- SWITCH:
  - Count SETTLE_CYCLES cycles, then cur_sel_o=target → DONE, err=0.
  - Stable deasserting during SWITCH is ignored; the select is never reverted mid-handoff.
- DONE:
  - done_o=1 for exactly one cycle, err_o valid in the same cycle and 0 otherwise.
  - Return to IDLE.
- Latency, handshake cycle = 0, target already stable at handshake:
  - Change request: clk_sel_o toggles at cycle 1 + SYNC_STAGES-dependent detection.
  - Exact timing: if synchronized stable is already high, clk_sel_o changes at cycle 1 after handshake. done_o is at cycle 1+SETTLE_CYCLES+1.
  - Same-select request: done_o at cycle 1.
- req_ready_o is low from the cycle after handshake until back in IDLE. Requests presented while busy are held by the requester, not dropped.
- clk_sel_o changes only in the WAIT_STABLE→SWITCH transition (or reset), at most once per request.
- Reset mid-operation returns immediately to the reset values and the request is lost. If the reset occurs during SWITCH, clk_sel_o reverts to RESET_SEL, and the glitchless mux is relied on for safety.
- Counter widths: $clog2 of max(TIMEOUT_CYCLES, SETTLE_CYCLES)+1; no wrap is reachable.

Test Plan:
- Reset then idle: rst_i pulse → clk_sel_o=0, cur_sel_o=0, req_ready_o=1, busy_o=0, done_o=0.
- Switch to stable clk1: clk1_stable_i held 1, request sel=1 → clk_sel_o=1 one cycle after handshake, done_o=1/err_o=0 at cycle 10 (SETTLE_CYCLES=8), cur_sel_o=1.
- Same-select request: cur_sel_o=1, request sel=1 → done_o at cycle 1, err_o=0, clk_sel_o never toggles.
- Late stable: clk0_stable_i=0, request sel=0, assert clk0_stable_i after 50 cycles → clk_sel_o=0 at 50+SYNC_STAGES(+1) cycles, done_o after a further SETTLE_CYCLES+1, err_o=0.
- Timeout: TIMEOUT_CYCLES=16, target stable held 0 → done_o=1, err_o=1 at cycle 17, clk_sel_o unchanged, req_ready_o=1 the next cycle.
- Reset mid-SWITCH and back-pressure:
  - rst_i asserted 3 cycles into SWITCH → clk_sel_o=RESET_SEL asynchronously and no done_o.
  - Request held valid while busy → accepted only after return to IDLE.
  - Exactly one done_o per handshake.
